// File: rtl/demux_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : demux_burst_scheduler
// Function : Round-robin burst sequencer driving the DEMUX_1_N select/enable.
//            Optional stall timeout: DEMUX_BURST_SCHEDULER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module demux_burst_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_OUT        = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic [NUM_OUT-1:0]    Mask_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  output logic                  Ready_Out,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic [NUM_OUT-1:0]    Valid_Out,
  input  logic [NUM_OUT-1:0]    Ready_In,
  output logic [SEL_WIDTH-1:0]  Select_Out,
  output logic                  Busy_Out,
  output logic [7:0]            Burst_Count_Out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] c_burst_len = 8'(BURST_LEN);

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic [NUM_OUT-1:0]    r_valid;
  logic [NUM_OUT-1:0]    w_onehot;
  logic [SEL_WIDTH-1:0]  r_select;
  logic [SEL_WIDTH-1:0]  r_ptr;
  logic [SEL_WIDTH:0]    w_grant;
  logic [7:0]            r_burst_cnt;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_burst_done;
  logic                  w_timeout;

  // Returns {found, index}: first set mask bit strictly after ptr, wrapping.
  // Walking the offsets downward lets the nearest candidate overwrite the rest.
  function automatic logic [SEL_WIDTH:0] next_grant(input logic [SEL_WIDTH-1:0] ptr,
                                                    input logic [NUM_OUT-1:0]   mask);
    logic [SEL_WIDTH:0] res;
    int                 idx;
    res = '0;
    for (int i = NUM_OUT; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_OUT;
      if (mask[idx[SEL_WIDTH-1:0]]) begin
        res = {1'b1, idx[SEL_WIDTH-1:0]};
      end
    end
    return res;
  endfunction

  assign w_grant = next_grant(r_ptr, Mask_In);

  always_comb begin
    w_onehot           = '0;
    w_onehot[r_select] = 1'b1;
  end

  assign w_ready      = (r_state == ST_XFER) & Enable_In & Mask_In[r_select] &
                        ((r_valid == '0) | Ready_In[r_select]);
  assign w_accept     = Valid_In & w_ready;
  assign w_drain      = (r_valid != '0) & Ready_In[r_select];
  assign w_burst_done = w_accept & ((r_burst_cnt + 8'd1) == c_burst_len);

`ifdef DEMUX_BURST_SCHEDULER_TIMEOUT_EN
  localparam int c_idle_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_idle_w-1:0] r_idle_cnt;

  // Leaving XFER clears the counter, so every new grant starts from zero.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_idle_cnt <= '0;
    end else if ((r_state != ST_XFER) || w_accept) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != c_idle_w'(TIMEOUT_CYCLES)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_XFER) & ~w_accept & (r_burst_cnt != 8'd0) &
                     (r_idle_cnt >= c_idle_w'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Enable_In && (Mask_In != '0)) begin
          w_state_next = ST_SEEK;
        end
      end
      ST_SEEK: begin
        w_state_next = (Enable_In && w_grant[SEL_WIDTH]) ? ST_XFER : ST_IDLE;
      end
      ST_XFER: begin
        if (w_burst_done || !Mask_In[r_select] || !Enable_In || w_timeout) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave only once the held word is gone, so the select never moves under it
        if ((r_valid == '0) || Ready_In[r_select]) begin
          w_state_next = Enable_In ? ST_SEEK : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_data      <= '0;
      r_valid     <= '0;
      r_select    <= '0;
      r_ptr       <= SEL_WIDTH'(NUM_OUT - 1);
      r_burst_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_data  <= Data_In;
        r_valid <= w_onehot;
      end else if (w_drain) begin
        r_valid <= '0;
      end

      if ((r_state == ST_SEEK) && (w_state_next == ST_XFER)) begin
        r_select    <= w_grant[SEL_WIDTH-1:0];
        r_ptr       <= w_grant[SEL_WIDTH-1:0];
        r_burst_cnt <= '0;
      end else if (w_accept) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end
    end
  end

  assign Ready_Out       = w_ready;
  assign Data_Out        = r_data;
  assign Valid_Out       = r_valid;
  assign Select_Out      = r_select;
  assign Busy_Out        = (r_state != ST_IDLE);
  assign Burst_Count_Out = r_burst_cnt;

endmodule
`default_nettype wire
